// File: rtl/inst_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and the ROM.
// One request outstanding at most; rom_ack carries rom_rdata in the same cycle.
interface inst_fetch_if;
    logic        rom_req;
    logic [31:0] rom_addr;
    logic        rom_ack;
    logic [31:0] rom_rdata;

    modport master (
        output rom_req,
        output rom_addr,
        input  rom_ack,
        input  rom_rdata
    );

    modport slave (
        input  rom_req,
        input  rom_addr,
        output rom_ack,
        output rom_rdata
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch stage: pc generation, ROM handshake, one-word stall buffer, IF output register.
// Optional macro IF_FETCH_CNT_EN enables the delivered-instruction counter on fetch_cnt.
module inst_fetch (
    input  logic                clk,
    input  logic                rst,
    input  logic                stall,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_i,
    inst_fetch_if.master        rom,
    output logic [31:0]         if_pc,
    output logic [31:0]         if_inst,
    output logic                if_valid,
    output logic [31:0]         fetch_cnt
);

    localparam logic        RstEnable = 1'b1;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_inst_q, if_inst_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;

    logic [31:0] branch_pc;
    logic [31:0] pc_inc;

    assign branch_pc = {branch_target_i[31:2], 2'b00};
    assign pc_inc    = pc_q + 32'd4;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH: begin
                if (!branch_flag_i && rom.rom_ack && stall) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (branch_flag_i || !stall) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs (request is suppressed combinationally during reset)
    // ---------------------------------------------------------------
    always_comb begin
        rom.rom_req  = 1'b0;
        rom.rom_addr = pc_q;
        if ((state_q == S_FETCH) && (rst != RstEnable)) begin
            rom.rom_req = 1'b1;
        end
    end

    // ---------------------------------------------------------------
    // Datapath next-state: pc, IF register, stall buffer
    // ---------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        if_pc_d    = if_pc_q;
        if_inst_d  = if_inst_q;
        if_valid_d = if_valid_q;
        buf_pc_d   = buf_pc_q;
        buf_inst_d = buf_inst_q;

        unique case (state_q)
            S_FETCH: begin
                if (branch_flag_i) begin
                    // Redirect wins; any word returned this cycle belongs to the old path.
                    pc_d       = branch_pc;
                    if_valid_d = 1'b0;
                    if_inst_d  = ZeroWord;
                end else if (rom.rom_ack && !stall) begin
                    if_pc_d    = pc_q;
                    if_inst_d  = rom.rom_rdata;
                    if_valid_d = 1'b1;
                    pc_d       = pc_inc;
                end else if (rom.rom_ack && stall) begin
                    buf_pc_d   = pc_q;
                    buf_inst_d = rom.rom_rdata;
                    pc_d       = pc_inc;
                end else if (!stall) begin
                    if_valid_d = 1'b0;
                    if_inst_d  = ZeroWord;
                end
            end
            S_HOLD: begin
                if (branch_flag_i) begin
                    pc_d       = branch_pc;
                    if_valid_d = 1'b0;
                    if_inst_d  = ZeroWord;
                    buf_pc_d   = ZeroWord;
                    buf_inst_d = ZeroWord;
                end else if (!stall) begin
                    if_pc_d    = buf_pc_q;
                    if_inst_d  = buf_inst_q;
                    if_valid_d = 1'b1;
                end
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            pc_q       <= ZeroWord;
            if_pc_q    <= ZeroWord;
            if_inst_q  <= ZeroWord;
            if_valid_q <= 1'b0;
            buf_pc_q   <= ZeroWord;
            buf_inst_q <= ZeroWord;
        end else begin
            pc_q       <= pc_d;
            if_pc_q    <= if_pc_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            buf_pc_q   <= buf_pc_d;
            buf_inst_q <= buf_inst_d;
        end
    end

    assign if_pc    = if_pc_q;
    assign if_inst  = if_inst_q;
    assign if_valid = if_valid_q;

    // ---------------------------------------------------------------
    // Delivered-instruction counter
    // ---------------------------------------------------------------
`ifdef IF_FETCH_CNT_EN
    logic [31:0] cnt_q, cnt_d;
    logic        deliver;

    // A delivery is any edge that loads a real instruction into the IF register.
    always_comb begin
        deliver = 1'b0;
        if (!branch_flag_i && !stall) begin
            if (state_q == S_FETCH) begin
                deliver = rom.rom_ack;
            end else begin
                deliver = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (deliver) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            cnt_q <= ZeroWord;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = ZeroWord;
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed testbench for inst_fetch: reset, streaming, stall/HOLD, branches, pc wrap, reset mid-HOLD.
module tb_inst_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_flag_i;
    logic [31:0] branch_target_i;
    logic        ack;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_valid;
    logic [31:0] fetch_cnt;

    int checks_total;
    int checks_passed;

    inst_fetch_if rom_bus ();

    // ROM contents: a distinct, address-derived word per location
    function automatic logic [31:0] rom_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_5A00;
    endfunction

    assign rom_bus.rom_ack   = ack;
    assign rom_bus.rom_rdata = rom_word(rom_bus.rom_addr);

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .rom             (rom_bus),
        .if_pc           (if_pc),
        .if_inst         (if_inst),
        .if_valid        (if_valid),
        .fetch_cnt       (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_val);
        checks_total++;
        if (obs === exp_val) begin
            checks_passed++;
            $display("check %-14s obs=%08h exp=%08h ok", tag, obs, exp_val);
        end else begin
            $display("FAIL %-14s obs=%08h exp=%08h", tag, obs, exp_val);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef IF_FETCH_CNT_EN
        return 32'(n);
`else
        return 32'(n) & 32'h0;
`endif
    endfunction

    task automatic chk_out(input string tag, input logic [31:0] pc_e, input logic v_e);
        chk({tag, ".valid"}, {31'd0, if_valid}, {31'd0, v_e});
        chk({tag, ".pc"}, if_pc, pc_e);
        chk({tag, ".inst"}, if_inst, v_e ? rom_word(pc_e) : 32'h0);
    endtask

    initial begin
        checks_total    = 0;
        checks_passed   = 0;
        rst             = 1'b1;
        stall           = 1'b0;
        branch_flag_i   = 1'b0;
        branch_target_i = 32'h0;
        ack             = 1'b1;

        // Reset with ack and branch active: both must be ignored
        tick();
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0400;
        tick();
        chk("rst.req", {31'd0, rom_bus.rom_req}, 32'd0);
        chk_out("rst", 32'h0, 1'b0);
        chk("rst.cnt", fetch_cnt, 32'h0);

        branch_flag_i = 1'b0;
        rst           = 1'b0;
        #1;
        chk("first.req", {31'd0, rom_bus.rom_req}, 32'd1);
        chk("first.addr", rom_bus.rom_addr, 32'h0);

        // Streaming fetch, ack every cycle
        tick();
        chk_out("s0", 32'h0, 1'b1);
        chk("s0.addr", rom_bus.rom_addr, 32'h4);
        tick();
        chk_out("s1", 32'h4, 1'b1);
        chk("s1.addr", rom_bus.rom_addr, 32'h8);

        // Ack at pc=0x8 while stalled -> HOLD for three cycles
        stall = 1'b1;
        tick();
        chk("hold.req", {31'd0, rom_bus.rom_req}, 32'd0);
        chk_out("hold0", 32'h4, 1'b1);
        tick();
        tick();
        chk("hold2.req", {31'd0, rom_bus.rom_req}, 32'd0);
        chk_out("hold2", 32'h4, 1'b1);
        stall = 1'b0;
        ack   = 1'b0;
        tick();
        chk_out("release", 32'h8, 1'b1);
        chk("release.addr", rom_bus.rom_addr, 32'hC);
        chk("release.req", {31'd0, rom_bus.rom_req}, 32'd1);
        ack = 1'b1;
        tick();
        chk_out("after", 32'hC, 1'b1);
        chk("cnt4", fetch_cnt, cnt_exp(4));

        // Branch with concurrent ack: returned word is dropped
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0103;
        tick();
        branch_flag_i = 1'b0;
        chk_out("br", 32'hC, 1'b0);
        chk("br.addr", rom_bus.rom_addr, 32'h100);
        tick();
        chk_out("br.tgt", 32'h100, 1'b1);

        // Branch while in HOLD: buffered word at 0x104 never appears
        stall = 1'b1;
        tick();
        chk("hb.req", {31'd0, rom_bus.rom_req}, 32'd0);
        branch_flag_i   = 1'b1;
        branch_target_i = 32'h0000_0200;
        tick();
        branch_flag_i = 1'b0;
        chk_out("hb", 32'h100, 1'b0);
        chk("hb.addr", rom_bus.rom_addr, 32'h200);
        stall = 1'b0;
        tick();
        chk_out("hb.tgt", 32'h200, 1'b1);

        // No ack, no stall -> bubble; then no ack with stall -> hold
        ack = 1'b0;
        tick();
        chk_out("bubble", 32'h200, 1'b0);
        ack = 1'b1;
        tick();
        chk_out("refill", 32'h204, 1'b1);
        ack   = 1'b0;
        stall = 1'b1;
        tick();
        chk_out("stallhold", 32'h204, 1'b1);
        chk("stallhold.adr", rom_bus.rom_addr, 32'h208);
        chk("cnt7", fetch_cnt, cnt_exp(7));

        // pc wrap at the top of the address space
        stall           = 1'b0;
        ack             = 1'b1;
        branch_flag_i   = 1'b1;
        branch_target_i = 32'hFFFF_FFFE;
        tick();
        branch_flag_i = 1'b0;
        chk("wrap.addr", rom_bus.rom_addr, 32'hFFFF_FFFC);
        tick();
        chk_out("wrap0", 32'hFFFF_FFFC, 1'b1);
        chk("wrap.addr2", rom_bus.rom_addr, 32'h0);
        tick();
        chk_out("wrap1", 32'h0, 1'b1);

        // Reset mid-HOLD after exactly five deliveries
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk_out("five", 32'h10, 1'b1);
        stall = 1'b1;
        tick();
        chk("pre.req", {31'd0, rom_bus.rom_req}, 32'd0);
        chk("pre.cnt", fetch_cnt, cnt_exp(5));
        rst           = 1'b1;
        branch_flag_i = 1'b1;
        tick();
        chk("in.req", {31'd0, rom_bus.rom_req}, 32'd0);
        chk("in.cnt", fetch_cnt, 32'h0);
        chk_out("in", 32'h0, 1'b0);
        rst           = 1'b0;
        branch_flag_i = 1'b0;
        stall         = 1'b0;
        #1;
        chk("post.addr", rom_bus.rom_addr, 32'h0);
        chk("post.req", {31'd0, rom_bus.rom_req}, 32'd1);
        tick();
        chk_out("post", 32'h0, 1'b1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
